// File: rtl/i2c_txn_arbiter.sv
// i2c_txn_arbiter: round-robin sequencer sharing one I2C master controller
// between NUM_REQ requesters. Latches the winner's address and byte count,
// drives the controller enable/address, and drops enable for the last byte
// so the controller issues STOP. Reports per-requester done/err pulses.
// Optional watchdog: define I2C_ARB_TIMEOUT_EN to abort after TIMEOUT_CYCLES
// cycles without progress.
module i2c_txn_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                 i2c_clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [8*NUM_REQ-1:0] req_addr_i,
  input  logic [4*NUM_REQ-1:0] req_len_i,
  input  logic                 ctrl_idle_i,
  input  logic                 ctrl_byte_done_i,
  input  logic                 ctrl_nack_i,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic [NUM_REQ-1:0]   done_o,
  output logic [NUM_REQ-1:0]   err_o,
  output logic                 busy_o,
  output logic                 ctrl_enable_o,
  output logic [7:0]           ctrl_slave_address_o
);

  localparam int unsigned IdxW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned AddrW = 8;
  localparam int unsigned LenW  = 4;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_XFER      = 3'd2,
    S_WAIT_IDLE = 3'd3,
    S_REPORT    = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [NUM_REQ-1:0]   err_q, err_d;
  logic                 busy_q, busy_d;
  logic                 en_q, en_d;
  logic [AddrW-1:0]     addr_q, addr_d;
  logic [IdxW-1:0]      rr_q, rr_d;
  logic [IdxW-1:0]      owner_q, owner_d;
  logic [LenW-1:0]      rem_q, rem_d;
  logic                 eflag_q, eflag_d;

  logic [AddrW-1:0]     addr_arr_c [NUM_REQ];
  logic [LenW-1:0]      len_arr_c  [NUM_REQ];
  logic                 win_found_c;
  logic [IdxW-1:0]      win_idx_c;
  logic                 timeout_c;

  // Position k places after the round-robin pointer, wrapped to NUM_REQ.
  function automatic logic [IdxW-1:0] rr_idx(input logic [IdxW-1:0] base,
                                             input int unsigned     k);
    return IdxW'((32'(base) + k) % NUM_REQ);
  endfunction

  // Unpack the flat per-requester address/length buses.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_arr_c[i] = req_addr_i[8*i +: 8];
      len_arr_c[i]  = req_len_i[4*i +: 4];
    end
  end

  // Round-robin search: first asserted request at rr_q, rr_q+1, ...
  always_comb begin
    win_found_c = 1'b0;
    win_idx_c   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!win_found_c && req_i[rr_idx(rr_q, k)]) begin
        win_found_c = 1'b1;
        win_idx_c   = rr_idx(rr_q, k);
      end
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int unsigned WdW = 16;

  logic [WdW-1:0] wd_q, wd_d;

  // Watchdog: cleared while idle and on byte progress, counts while active.
  always_comb begin
    wd_d = wd_q;
    if (state_q == S_IDLE) begin
      wd_d = '0;
    end else if (state_q == S_XFER && ctrl_byte_done_i) begin
      wd_d = '0;
    end else if ((state_q == S_START || state_q == S_XFER ||
                  state_q == S_WAIT_IDLE) && (wd_q != '1)) begin
      wd_d = wd_q + WdW'(1);
    end
  end

  assign timeout_c = (wd_q >= WdW'(TIMEOUT_CYCLES - 1));

  // Watchdog register.
  always_ff @(posedge i2c_clk or negedge rst_n) begin
    if (!rst_n) wd_q <= '0;
    else        wd_q <= wd_d;
  end
`else
  logic unused_timeout;

  assign timeout_c      = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    done_d  = '0;
    err_d   = '0;
    busy_d  = busy_q;
    en_d    = en_q;
    addr_d  = addr_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    rem_d   = rem_q;
    eflag_d = eflag_q;

    case (state_q)
      S_IDLE: begin
        if (win_found_c && ctrl_idle_i) begin
          owner_d = win_idx_c;
          grant_d = NUM_REQ'(1) << win_idx_c;
          addr_d  = addr_arr_c[win_idx_c];
          rem_d   = (len_arr_c[win_idx_c] == '0) ? LenW'(1) : len_arr_c[win_idx_c];
          busy_d  = 1'b1;
          en_d    = 1'b1;
          eflag_d = 1'b0;
          state_d = S_START;
        end
      end

      S_START: begin
        en_d = 1'b1;
        if (ctrl_nack_i || timeout_c) begin
          eflag_d = 1'b1;
          en_d    = 1'b0;
          state_d = S_WAIT_IDLE;
        end else if (!ctrl_idle_i) begin
          en_d    = (rem_q > LenW'(1));
          state_d = S_XFER;
        end
      end

      S_XFER: begin
        if (ctrl_nack_i) begin
          eflag_d = 1'b1;
          en_d    = 1'b0;
          state_d = S_WAIT_IDLE;
        end else if (ctrl_byte_done_i) begin
          if (rem_q <= LenW'(1)) begin
            rem_d   = '0;
            en_d    = 1'b0;
            state_d = S_WAIT_IDLE;
          end else begin
            rem_d = rem_q - LenW'(1);
            en_d  = (rem_q > LenW'(2));
          end
        end else if (timeout_c) begin
          eflag_d = 1'b1;
          en_d    = 1'b0;
          state_d = S_WAIT_IDLE;
        end else begin
          en_d = (rem_q > LenW'(1));
        end
      end

      S_WAIT_IDLE: begin
        en_d = 1'b0;
        if (ctrl_idle_i) begin
          state_d = S_REPORT;
        end else if (timeout_c) begin
          eflag_d = 1'b1;
          state_d = S_REPORT;
        end
      end

      S_REPORT: begin
        done_d[owner_q] = ~eflag_q;
        err_d[owner_q]  = eflag_q;
        grant_d = '0;
        busy_d  = 1'b0;
        en_d    = 1'b0;
        eflag_d = 1'b0;
        rr_d    = (owner_q == IdxW'(NUM_REQ - 1)) ? '0 : owner_q + IdxW'(1);
        state_d = S_IDLE;
      end

      default: begin
        grant_d = '0;
        busy_d  = 1'b0;
        en_d    = 1'b0;
        eflag_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge i2c_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      done_q  <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      en_q    <= 1'b0;
      addr_q  <= '0;
      rr_q    <= '0;
      owner_q <= '0;
      rem_q   <= '0;
      eflag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      en_q    <= en_d;
      addr_q  <= addr_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      rem_q   <= rem_d;
      eflag_q <= eflag_d;
    end
  end

  assign grant_o              = grant_q;
  assign done_o               = done_q;
  assign err_o                = err_q;
  assign busy_o               = busy_q;
  assign ctrl_enable_o        = en_q;
  assign ctrl_slave_address_o = addr_q;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Bench for i2c_txn_arbiter: the bench plays requesters and I2C controller,
// and checks against a transaction-level round-robin model.
module tb_i2c_txn_arbiter;

  localparam int unsigned N = 4;

  logic           i2c_clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [8*N-1:0] req_addr;
  logic [4*N-1:0] req_len;
  logic           ctrl_idle;
  logic           ctrl_byte_done;
  logic           ctrl_nack;
  logic [N-1:0]   grant;
  logic [N-1:0]   done;
  logic [N-1:0]   err;
  logic           busy;
  logic           ctrl_enable;
  logic [7:0]     ctrl_slave_address;

  i2c_txn_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(16)) dut (
    .i2c_clk              (i2c_clk),
    .rst_n                (rst_n),
    .req_i                (req),
    .req_addr_i           (req_addr),
    .req_len_i            (req_len),
    .ctrl_idle_i          (ctrl_idle),
    .ctrl_byte_done_i     (ctrl_byte_done),
    .ctrl_nack_i          (ctrl_nack),
    .grant_o              (grant),
    .done_o               (done),
    .err_o                (err),
    .busy_o               (busy),
    .ctrl_enable_o        (ctrl_enable),
    .ctrl_slave_address_o (ctrl_slave_address)
  );

  always #5 i2c_clk = ~i2c_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: round-robin pointer and per-requester parameters.
  int         rr_m;
  logic [7:0] addr_m [N];
  int         len_m  [N];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int base);
    for (int k = 0; k < N; k++) begin
      if (r[(base + k) % N]) return (base + k) % N;
    end
    return 0;
  endfunction

  task automatic drive_req(input logic [N-1:0] r);
    req = r;
    for (int i = 0; i < N; i++) begin
      req_addr[8*i +: 8] = addr_m[i];
      req_len[4*i +: 4]  = 4'(len_m[i]);
    end
  endtask

  task automatic wait_grant();
    for (int c = 0; c < 6; c++) begin
      @(negedge i2c_clk);
      if (grant != '0) break;
    end
  endtask

  // One transaction. mode 0: normal, 1: NACK in START, 2: NACK at byte nack_k.
  task automatic run_txn(input logic [N-1:0] r, input int mode, input int nack_k_in,
                         input bit nack_bd);
    int w, len, nack_k;
    logic [7:0] a;
    logic [N-1:0] exp_done, exp_err;
    bit aborted;
    w   = pick(r, rr_m);
    a   = addr_m[w];
    len = (len_m[w] == 0) ? 1 : len_m[w];
    nack_k = (nack_k_in == 0) ? int'($urandom_range(1, len)) : nack_k_in;
    aborted = (mode == 1) || (mode == 2 && nack_k <= len);
    @(negedge i2c_clk);
    drive_req(r);
    wait_grant();
    check("grant", 32'(grant), 32'(1) << w);
    check("addr", 32'(ctrl_slave_address), 32'(a));
    check("busy", 32'(busy), 32'd1);
    check("en_start", 32'(ctrl_enable), 32'd1);
    // Requester side changes after grant must not affect the transaction.
    req      = 4'($urandom);
    req_addr = $urandom;
    req_len  = 16'($urandom);
    repeat ($urandom_range(0, 2)) @(negedge i2c_clk);
    if (mode == 1) begin
      ctrl_nack = 1'b1;
      @(negedge i2c_clk);
      ctrl_nack = 1'b0;
      check("en_nack_start", 32'(ctrl_enable), 32'd0);
    end else begin
      ctrl_idle = 1'b0;
      repeat ($urandom_range(1, 2)) @(negedge i2c_clk);
      for (int k = 1; k <= len; k++) begin
        check("en_byte", 32'(ctrl_enable), 32'(k < len));
        if (mode == 2 && k == nack_k) begin
          ctrl_nack      = 1'b1;
          ctrl_byte_done = nack_bd;
          @(negedge i2c_clk);
          ctrl_nack      = 1'b0;
          ctrl_byte_done = 1'b0;
          break;
        end
        ctrl_byte_done = 1'b1;
        @(negedge i2c_clk);
        ctrl_byte_done = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge i2c_clk);
      end
      check("en_end", 32'(ctrl_enable), 32'd0);
      repeat ($urandom_range(0, 2)) @(negedge i2c_clk);
      ctrl_idle = 1'b1;
    end
    exp_done = aborted ? '0 : N'(1) << w;
    exp_err  = aborted ? N'(1) << w : '0;
    for (int c = 0; c < 8; c++) begin
      @(negedge i2c_clk);
      if ((done | err) != '0) break;
    end
    check("done", 32'(done), 32'(exp_done));
    check("err", 32'(err), 32'(exp_err));
    check("grant_free", 32'(grant), 32'd0);
    check("busy_free", 32'(busy), 32'd0);
    check("addr_hold", 32'(ctrl_slave_address), 32'(a));
    rr_m = (w + 1) % N;
    // Controller strobes while idle must be ignored.
    req            = '0;
    ctrl_byte_done = 1'b1;
    ctrl_nack      = 1'b1;
    @(negedge i2c_clk);
    ctrl_byte_done = 1'b0;
    ctrl_nack      = 1'b0;
    check("pulse_width", 32'({done, err}), 32'd0);
    @(negedge i2c_clk);
    check("idle_strobe", 32'({busy, ctrl_enable, done, err}), 32'd0);
  endtask

  initial begin
    bit seen_rpt;
    rst_n = 1'b0;
    req = '0; req_addr = '0; req_len = '0;
    ctrl_idle = 1'b1; ctrl_byte_done = 1'b0; ctrl_nack = 1'b0;
    rr_m = 0;
    for (int i = 0; i < N; i++) begin addr_m[i] = 8'h00; len_m[i] = 1; end
    repeat (2) @(negedge i2c_clk);
    check("rst_outs", 32'({grant, done, err, busy, ctrl_enable, ctrl_slave_address}), 32'd0);
    rst_n = 1'b1;

    // All requesting with single-byte transactions: strict rotation.
    for (int i = 0; i < N; i++) begin addr_m[i] = 8'(8'h10 + 2 * i); len_m[i] = 1; end
    repeat (5) run_txn(4'b1111, 0, 0, 1'b0);

    // Requester 1, address A0, three bytes.
    addr_m[1] = 8'hA0; len_m[1] = 3;
    run_txn(4'b0010, 0, 0, 1'b0);
    check("rr_after_1", 32'(rr_m), 32'd2);

    // NACK during START for requester 0.
    addr_m[0] = 8'h50; len_m[0] = 2;
    run_txn(4'b0001, 1, 0, 1'b0);

    // Byte completion and NACK on the same cycle: error wins.
    addr_m[3] = 8'h3C; len_m[3] = 2;
    run_txn(4'b1000, 2, 2, 1'b1);

    // Zero length counts as one byte.
    addr_m[2] = 8'h77; len_m[2] = 0;
    run_txn(4'b0100, 0, 0, 1'b0);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      int m;
      for (int i = 0; i < N; i++) begin
        addr_m[i] = 8'($urandom);
        len_m[i]  = int'($urandom_range(0, 5));
      end
      m = int'($urandom_range(0, 5));
      run_txn(4'($urandom_range(1, 15)), (m == 0) ? 1 : (m == 1) ? 2 : 0, 0, 1'($urandom));
    end

    // Asynchronous reset in the middle of a transfer.
    for (int i = 0; i < N; i++) begin addr_m[i] = 8'(8'h20 + i); len_m[i] = 3; end
    if (rr_m == 0) run_txn(4'b0001, 0, 0, 1'b0);
    @(negedge i2c_clk);
    drive_req(4'b1111);
    wait_grant();
    ctrl_idle = 1'b0;
    repeat (2) @(negedge i2c_clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst", 32'({grant, done, err, busy, ctrl_enable, ctrl_slave_address}), 32'd0);
    req = '0;
    @(negedge i2c_clk);
    rst_n = 1'b1;
    ctrl_idle = 1'b1;
    rr_m = 0;
    run_txn(4'b1111, 0, 0, 1'b0);

    // Controller stuck busy with no byte progress.
    addr_m[1] = 8'h42; len_m[1] = 2;
    @(negedge i2c_clk);
    drive_req(4'b0010);
    wait_grant();
    check("grant_stuck", 32'(grant), 32'b0010);
    req = '0;
    ctrl_idle = 1'b0;
    seen_rpt = 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
    for (int c = 0; c < 40; c++) begin
      @(negedge i2c_clk);
      if ((done | err) != '0) break;
    end
    check("timeout_err", 32'(err), 32'b0010);
    check("timeout_done", 32'(done), 32'd0);
    ctrl_idle = 1'b1;
    @(negedge i2c_clk);
    check("timeout_free", 32'(busy), 32'd0);
`else
    for (int c = 0; c < 40; c++) begin
      @(negedge i2c_clk);
      if ((done | err) != '0) seen_rpt = 1'b1;
    end
    check("stuck_busy", 32'(busy), 32'd1);
    check("stuck_no_rpt", 32'(seen_rpt), 32'd0);
    rst_n = 1'b0;
    @(negedge i2c_clk);
    rst_n = 1'b1;
    ctrl_idle = 1'b1;
    @(negedge i2c_clk);
    check("stuck_rst", 32'(busy), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
